// File: rtl/cmp_pkg.sv
// Shared definitions for the nibble-serial cascade comparator.
//   state_t  : controller states
//   casc_t   : 7485-style cascade triple {l, e, g}
//   CASC_RST : cascade value that means "equal" (L=0, E=1, G=0)
package cmp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } casc_t;

  localparam casc_t CASC_RST = '{l: 1'b0, e: 1'b1, g: 1'b0};

endpackage

// File: rtl/nibble_cmp4.sv
// Combinational 4-bit magnitude compare with cascade in/out.
// A differing nibble overrides the incoming cascade; equal nibbles pass it on.
//   i_a, i_b : nibbles to compare
//   i_casc   : cascade from the lower-significance nibbles
//   o_casc   : cascade including this nibble
module nibble_cmp4
  import cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  casc_t               i_casc,
  output casc_t               o_casc
);

  always_comb begin
    o_casc = i_casc;
    if (i_a > i_b) begin
      o_casc = '{l: 1'b0, e: 1'b0, g: 1'b1};
    end else if (i_a < i_b) begin
      o_casc = '{l: 1'b1, e: 1'b0, g: 1'b0};
    end
  end

endmodule

// File: rtl/nibble_serial_cascade_cmp.sv
// Sequential magnitude comparator: one nibble per clock, LSB nibble first.
// Processing LSB first lets a higher differing nibble overwrite any lower
// decision, so the seed survives only when every nibble is equal.
//   clk, rst_n      : clock, async active-low reset
//   start           : request compare, accepted in IDLE or DONE
//   a, b            : unsigned operands, captured on accept
//   Lin, Ein, Gin   : cascade seed, captured on accept (not validated)
//   busy            : nibbles being processed
//   done            : one-cycle pulse, L/E/G just updated
//   L, E, G         : registered result, held until the next done
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble compared per cycle
// DONE  | result valid for one cycle; start accepted as in IDLE
module nibble_serial_cascade_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Lin,
  input  logic             Ein,
  input  logic             Gin,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [IW-1:0]         r_idx;
  casc_t                 r_casc;
  casc_t                 r_res;
  casc_t                 w_casc_nxt;
  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic                  w_accept;
  logic                  w_last;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == LAST_IDX);

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_cmp4 u_nibble_cmp4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_casc (r_casc),
    .o_casc (w_casc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // Working cascade r_casc is kept apart from r_res so L/E/G stay frozen
  // during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_casc <= CASC_RST;
      r_res  <= CASC_RST;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_idx  <= '0;
      r_casc <= '{l: Lin, e: Ein, g: Gin};
    end else if (r_state == RUN) begin
      r_casc <= w_casc_nxt;
      r_idx  <= r_idx + 1'b1;
      if (w_last) begin
        r_res <= w_casc_nxt;
      end
    end
  end

  assign L = r_res.l;
  assign E = r_res.e;
  assign G = r_res.g;

endmodule
